// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types, including pipeline latch states and stage payloads
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    npc;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  function automatic logic pipe_holds(input pipe_state_t s);
    return s != EMPTY;
  endfunction

endpackage

// File: rtl/pipe_latch_sat_counter.sv
// sat_counter: CNT_W-bit incrementer that sticks at all-ones, cleared by synchronous reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // count up on i_inc until every bit is set, then hold
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_latch.sv
// pipe_latch: valid/ready inter-stage register with flush and stall counter; PIPE_LATCH_SKID_EN adds a skid entry and registered in_ready
module pipe_latch
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      r_state, w_state_nx;
  logic [WIDTH-1:0] r_main, w_main_nx;
  logic             w_stall;
`ifdef PIPE_LATCH_SKID_EN
  logic [WIDTH-1:0] r_skid, w_skid_nx;
`endif

  // next state and register loads; flush wins over any handshake in the same cycle
  always_comb begin
    w_state_nx = r_state;
    w_main_nx  = r_main;
`ifdef PIPE_LATCH_SKID_EN
    w_skid_nx  = r_skid;
`endif
    if (flush) begin
      w_state_nx = EMPTY;
      w_main_nx  = '0;
`ifdef PIPE_LATCH_SKID_EN
      w_skid_nx  = '0;
`endif
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_valid) begin
            w_state_nx = FULL;
            w_main_nx  = in_data;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) w_main_nx = in_data;
            else w_state_nx = EMPTY;
          end
`ifdef PIPE_LATCH_SKID_EN
          else if (in_valid) begin
            w_state_nx = SKID;
            w_skid_nx  = in_data;
          end
`endif
        end
`ifdef PIPE_LATCH_SKID_EN
        SKID: begin
          if (out_ready) begin
            w_state_nx = FULL;
            w_main_nx  = r_skid;
          end
        end
`endif
        default: w_state_nx = r_state;
      endcase
    end
  end

  // state and main payload registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_main  <= w_main_nx;
    end
  end

`ifdef PIPE_LATCH_SKID_EN
  // skid entry holds the one word upstream may push after back-pressure starts
  always_ff @(posedge CLK) begin
    if (RST) r_skid <= '0;
    else r_skid <= w_skid_nx;
  end

  assign in_ready = r_state != SKID;
`else
  assign in_ready = out_ready || !out_valid;
`endif

  assign out_valid = pipe_holds(r_state);
  assign out_data  = r_main;
  assign w_stall   = out_valid && !out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_latch.sv
// tb_pipe_latch: directed checks of pipe_latch streaming, back-pressure, flush, saturation and reset
module tb_pipe_latch;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  int               checks = 0;
  int               errors = 0;

  pipe_latch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h1111_0000_0000_0000 | 64'(i);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", out_data, 64'h1111_0000_0000_0000 | 64'(i));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hAAAA_AAAA_0000_000A;
    tick();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_data", out_data, 64'hAAAA_AAAA_0000_000A);
    in_data = 64'hBBBB_BBBB_0000_000B;
    #1;
`ifdef PIPE_LATCH_SKID_EN
    chk("bp_full_in_ready", 64'(in_ready), 64'd1);
`else
    chk("bp_comb_in_ready", 64'(in_ready), 64'd0);
`endif
    tick();
    chk("bp_b_data", out_data, 64'hAAAA_AAAA_0000_000A);
    chk("bp_b_in_ready", 64'(in_ready), 64'd0);
    chk("bp_b_stall", 64'(stall_cnt), 64'd1);
    in_data = 64'hCCCC_CCCC_0000_000C;
    tick();
    chk("bp_c_data", out_data, 64'hAAAA_AAAA_0000_000A);
    chk("bp_c_stall", 64'(stall_cnt), 64'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
`ifdef PIPE_LATCH_SKID_EN
    chk("rel_b_valid", 64'(out_valid), 64'd1);
    chk("rel_b_data", out_data, 64'hBBBB_BBBB_0000_000B);
    chk("rel_b_in_ready", 64'(in_ready), 64'd1);
`else
    chk("rel_no_extra", 64'(out_valid), 64'd0);
`endif
    chk("rel_stall", 64'(stall_cnt), 64'd2);
    tick();
    chk("rel_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA2A2_0000_0000_00A2;
    tick();
    in_data = 64'hB2B2_0000_0000_00B2;
    tick();
    chk("pre_flush_stall", 64'(stall_cnt), 64'd3);
    chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 64'hC2C2_0000_0000_00C2;
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", out_data, 64'd0);
    chk("flush_stall", 64'(stall_cnt), 64'd3);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    chk("post_flush_data", out_data, 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDDDD_0000_0000_000D;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("sat_14", 64'(stall_cnt), 64'd14);
    tick();
    chk("sat_15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_hold", 64'(stall_cnt), 64'd15);
    chk("sat_data", out_data, 64'hDDDD_0000_0000_000D);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hEEEE_0000_0000_000E;
    RST       = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    RST     = 1'b0;
    in_data = 64'hFFFF_0000_0000_000F;
    tick();
    chk("resume_valid", 64'(out_valid), 64'd1);
    chk("resume_data", out_data, 64'hFFFF_0000_0000_000F);
    in_valid = 1'b0;
    tick();
    chk("resume_drain", 64'(out_valid), 64'd0);
    chk("resume_stall", 64'(stall_cnt), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_latch.md
# pipe_latch

Parametrised inter-stage pipeline register for the CPU datapath, the general form of the per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload between stages with a valid/ready handshake, synchronous flush, and a saturating back-pressure (stall) counter. An optional one-entry skid buffer registers `in_ready`, which breaks the combinational ready path through the pipeline.

## Interface
Parameters:
- `WIDTH`, default 64: payload width, for example 32-bit instruction plus 32-bit next PC.
- `CNT_W`, default 16: stall counter width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `flush` in 1: discard all held and incoming data.
- `in_valid` in 1: upstream stage offers data.
- `in_data` in `WIDTH`: upstream payload.
- `in_ready` out 1: the latch accepts data this cycle.
- `out_valid` out 1: the latch presents data downstream.
- `out_data` out `WIDTH`: payload for the downstream stage.
- `out_ready` in 1: downstream stage consumes data this cycle.
- `stall_cnt` out `CNT_W`: count of back-pressured cycles.

## Operation
- **Transfers.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **State machine** (skid build): states EMPTY, FULL, SKID.
  - EMPTY: `in_valid` → FULL, main register <= `in_data`.
  - FULL, `in_valid && out_ready`: stay FULL, main <= `in_data`.
  - FULL, `!in_valid && out_ready`: → EMPTY.
  - FULL, `in_valid && !out_ready`: → SKID, skid register <= `in_data`.
  - FULL, otherwise: hold.
  - SKID: `out_ready` → FULL, main <= skid. Otherwise hold. `in_ready` is 0 in SKID, so no input is accepted.
- **Outputs.**
  - `out_valid` = (state != EMPTY).
  - `out_data` = main register.
  - `in_ready` = (state != SKID), decoded from registered state only.
- **Priority.** `RST` > `flush` > normal operation.
- **Flush.**
  - Next state is EMPTY; main and skid registers are cleared to 0.
  - Any same-cycle `in_data` is dropped, even if the input handshake shows a transfer.
  - A flush in SKID discards both entries.
- **Stall counter.**
  - Increments on every cycle with `out_valid && !out_ready`.
  - Saturates at 2^`CNT_W`-1 and does not wrap.
  - Cleared by `RST` only; `flush` does not affect it.
- **Data integrity.** Data order is preserved. No entry is duplicated or lost except by flush.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=1, `stall_cnt`=0, state EMPTY, skid register 0.
- Latency: data accepted at edge N appears on `out_data` after edge N, one cycle.
- Throughput: one transfer per cycle while `out_ready` is held high.
- Skid build: `in_ready` falls one cycle after the first back-pressured cycle that also had an input transfer. Upstream may therefore push exactly one extra word, which the skid register holds.
- Reset or flush asserted mid-transfer: takes effect at that edge; the output is empty on the next cycle.
- Simultaneous `flush` and `out_ready`: the output transfer in that cycle counts, so downstream has consumed `out_data`. Flush clears the state afterwards.

## Configuration
- `PIPE_LATCH_SKID_EN` defined:
  - Three-state machine and skid register as above.
  - `in_ready` driven from registered state only.
- `PIPE_LATCH_SKID_EN` undefined:
  - Two states only, EMPTY and FULL; no skid register.
  - `in_ready` = `out_ready || !out_valid`, which is combinational.
  - Transfers, flush, reset and counter behaviour are otherwise identical.

## Structure
- `cpu_types_pkg` gains `pipe_state_t`, an enum with EMPTY, FULL and SKID.
- Stage payload structs (for example the IF/ID instruction/NPC pair) live in `cpu_types_pkg` and are passed as the `WIDTH`-bit vector.
- One sub-module: `sat_counter`, a parametrised `CNT_W` saturating incrementer with synchronous clear, used for `stall_cnt`.

## Test plan
- Stream with `out_ready`=1: push 0x...01 to 0x...08 on consecutive cycles → same 8 values out, one cycle later, no gaps; `stall_cnt`=0.
- Back-pressure (skid build): push A, B while `out_ready`=0 → state SKID, `in_ready`=0, `stall_cnt` counts. Release `out_ready` → A then B delivered in order.
- Flush in SKID with `in_valid`=1 carrying C → next cycle `out_valid`=0, `out_data`=0; A, B and C all gone; `stall_cnt` unchanged.
- `CNT_W`=4, hold `out_valid`=1 with `out_ready`=0 for 20 cycles → `stall_cnt` stops at 15.
- Assert `RST` for one cycle mid-stream → next cycle `out_valid`=0, `in_ready`=1, `stall_cnt`=0; streaming resumes.
- Build without `PIPE_LATCH_SKID_EN`: drive `out_ready` low while FULL → `in_ready` drops in the same cycle; no third value is ever accepted.
